// File: rtl/dff_async_reset.sv
// dff_async_reset: WIDTH-bit edge-triggered D register with an asynchronous,
// active-high reset and a complemented output.
//
// Parameters:
//   WIDTH       - number of bits stored (D, Q, notQ are all WIDTH bits)
//   RESET_VALUE - value forced onto Q while asyncReset is high
//
// Ports:
//   clk        in   1      rising-edge clock
//   asyncReset in   1      asynchronous reset, active high; overrides everything
//   en         in   1      clock enable (only when DFF_ASYNC_RESET_CLOCK_ENABLE_EN is defined)
//   D          in   WIDTH  data captured on the rising edge of clk
//   Q          out  WIDTH  registered data
//   notQ       out  WIDTH  bitwise complement of Q (combinational, never registered)
//
// Optional feature: define DFF_ASYNC_RESET_CLOCK_ENABLE_EN to add the en port.
// Without it the register loads D on every rising edge outside reset.

module dff_async_reset #(
  parameter int unsigned      WIDTH       = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             asyncReset,
`ifdef DFF_ASYNC_RESET_CLOCK_ENABLE_EN
  input  logic             en,
`endif
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] notQ
);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;

`ifdef DFF_ASYNC_RESET_CLOCK_ENABLE_EN
  always_comb begin
    q_d = q_q;
    if (en) begin
      q_d = D;
    end
  end
`else
  always_comb begin
    q_d = D;
  end
`endif

  // Reset is in the sensitivity list so Q clears without waiting for clk.
  always_ff @(posedge clk or posedge asyncReset) begin
    if (asyncReset) begin
      q_q <= RESET_VALUE;
    end else begin
      q_q <= q_d;
    end
  end

  assign Q    = q_q;
  // Derived from the same register so it can never disagree with Q.
  assign notQ = ~q_q;

endmodule

// File: tb/tb_dff_async_reset.sv
module tb_dff_async_reset;

  localparam logic [7:0] Rv8 = 8'hA5;

  logic       clk;
  logic       rst;
  logic       en;
  logic       d1;
  logic       q1;
  logic       nq1;
  logic [7:0] d8;
  logic [7:0] q8;
  logic [7:0] nq8;

  int checks;
  int errors;

  dff_async_reset #(
    .WIDTH      (1),
    .RESET_VALUE(1'b0)
  ) u_dut1 (
    .clk       (clk),
    .asyncReset(rst),
`ifdef DFF_ASYNC_RESET_CLOCK_ENABLE_EN
    .en        (en),
`endif
    .D         (d1),
    .Q         (q1),
    .notQ      (nq1)
  );

  dff_async_reset #(
    .WIDTH      (8),
    .RESET_VALUE(Rv8)
  ) u_dut8 (
    .clk       (clk),
    .asyncReset(rst),
`ifdef DFF_ASYNC_RESET_CLOCK_ENABLE_EN
    .en        (en),
`endif
    .D         (d8),
    .Q         (q8),
    .notQ      (nq8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic chk_all(input string name, input logic e1, input logic [7:0] e8);
    chk({name, ".q1"}, {7'd0, q1}, {7'd0, e1});
    chk({name, ".nq1"}, {7'd0, nq1}, {7'd0, ~e1});
    chk({name, ".q8"}, q8, e8);
    chk({name, ".nq8"}, nq8, ~e8);
  endtask

  typedef struct {
    logic       rst;
    logic       d1;
    logic [7:0] d8;
    logic       exp1;
    logic [7:0] exp8;
  } vec_t;

  vec_t vecs[6];

  initial begin
    logic       m1;
    logic [7:0] m8;
    int         mode;
    checks = 0;
    errors = 0;

    vecs[0] = '{rst: 1'b0, d1: 1'b1, d8: 8'h12, exp1: 1'b1, exp8: 8'h12};
    vecs[1] = '{rst: 1'b0, d1: 1'b0, d8: 8'hFF, exp1: 1'b0, exp8: 8'hFF};
    vecs[2] = '{rst: 1'b1, d1: 1'b1, d8: 8'h77, exp1: 1'b0, exp8: Rv8};
    vecs[3] = '{rst: 1'b1, d1: 1'b0, d8: 8'h00, exp1: 1'b0, exp8: Rv8};
    vecs[4] = '{rst: 1'b0, d1: 1'b1, d8: 8'h81, exp1: 1'b1, exp8: 8'h81};
    vecs[5] = '{rst: 1'b0, d1: 1'b1, d8: 8'h00, exp1: 1'b1, exp8: 8'h00};

    // Timed sequence; rising edges at 5, 15, 25, ...
    rst = 1'b0; en = 1'b1; d1 = 1'b0; d8 = 8'h3C;
    #10;  // t=10
    chk_all("first_capture", 1'b0, 8'h3C);
    #20 d1 = 1'b1;  // t=30
    #4;   // t=34
    chk("no_early_capture", {7'd0, q1}, 8'h00);
    #2;   // t=36
    chk("capture_one.q", {7'd0, q1}, 8'h01);
    chk("capture_one.nq", {7'd0, nq1}, 8'h00);
    #14 rst = 1'b1;  // t=50, between edges
    #1;   // t=51
    chk_all("async_assert", 1'b0, Rv8);
    #5;   // t=56, after the 55 ns edge with D=1
    chk_all("reset_hold", 1'b0, Rv8);
    #4 rst = 1'b0;  // t=60
    #4;   // t=64
    chk("release_no_early", {7'd0, q1}, 8'h00);
    #2;   // t=66
    chk_all("release_capture", 1'b1, 8'h3C);
    #4 d1 = 1'b0;  // t=70
    #6 chk("toggle_75", {7'd0, q1}, 8'h00);  // t=76
    #4 d1 = 1'b1;  // t=80
    #6 chk("toggle_85", {7'd0, q1}, 8'h01);  // t=86
    #4 d1 = 1'b0;  // t=90
    #6 chk("toggle_95", {7'd0, q1}, 8'h00);  // t=96
    #70;  // t=166
    chk("hold_to_165.q", {7'd0, q1}, 8'h00);
    chk("hold_to_165.nq", {7'd0, nq1}, 8'h01);
    #4 d1 = 1'b1;  // t=170
    #5 rst = 1'b1; // t=175, coincident with a rising edge
    #1;   // t=176
    chk_all("reset_vs_edge", 1'b0, Rv8);
    #4 rst = 1'b0;  // t=180
    #6;   // t=186
    chk_all("after_reset_vs_edge", 1'b1, 8'h3C);

`ifdef DFF_ASYNC_RESET_CLOCK_ENABLE_EN
    @(negedge clk);
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      d1 = i[0];
      d8 = 8'(i + 8'h50);
      @(posedge clk);
      #1 chk_all("en_low_hold", 1'b1, 8'h3C);
      @(negedge clk);
    end
    en = 1'b1; d1 = 1'b0; d8 = 8'h66;
    @(posedge clk);
    #1 chk_all("en_high_load", 1'b0, 8'h66);
    @(negedge clk);
    en = 1'b0; d1 = 1'b1;
    rst = 1'b1;
    #1 chk_all("en_low_reset", 1'b0, Rv8);
    rst = 1'b0;
    en = 1'b1;
`endif

    // Table-driven vectors: apply at the falling edge, check after the rising edge.
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      rst = vecs[i].rst;
      d1  = vecs[i].d1;
      d8  = vecs[i].d8;
      @(posedge clk);
      #1 chk_all($sformatf("vec%0d", i), vecs[i].exp1, vecs[i].exp8);
    end

    // Randomised run against a reference model: Q is the last D seen at a rising
    // edge outside reset, or the reset value while reset is high.
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      mode = int'($urandom_range(0, 7));
      d1 = 1'($urandom);
      d8 = 8'($urandom);
      rst = (mode == 0);
      if (mode == 1) begin
        // Short reset pulse between edges.
        #1 rst = 1'b1;
        #1 chk_all("rand_pulse", 1'b0, Rv8);
        rst = 1'b0;
      end
      m1 = rst ? 1'b0 : d1;
      m8 = rst ? Rv8 : d8;
      @(posedge clk);
      #1 chk_all("rand_edge", m1, m8);
      // Data changes between edges must not reach Q.
      #1 d1 = 1'($urandom);
      d8 = 8'($urandom);
      #1 chk_all("rand_stable", m1, m8);
    end
    rst = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dff_async_reset.md
Name: dff_async_reset

Overview:
- Single-clock, edge-triggered D-type register with an asynchronous, active-high reset.
- Provides true and complemented outputs.
- Width is parameterisable; the default is a 1-bit flop.
- Used as a basic storage and state element wherever a register must clear immediately on reset, without waiting for a clock edge.

Parameters:
- WIDTH, 1, number of bits stored; D, Q and notQ are all WIDTH bits.
- RESET_VALUE, {WIDTH{1'b0}}, value loaded into Q while asyncReset is high.

Ports:
- clk  input  1  clock; all state updates occur on the rising edge.
- asyncReset  input  1  asynchronous, active-high reset.
- D  input  WIDTH  data captured on the rising edge of clk.
- Q  output  WIDTH  registered data.
- notQ  output  WIDTH  bitwise complement of Q.

Interface decision: one clock (clk); reset is asynchronous and active-high (asyncReset).

Behaviour:
- Reset assertion:
  - On the rising edge of asyncReset, Q becomes RESET_VALUE immediately, with no clock edge needed.
  - notQ becomes ~RESET_VALUE immediately.
- Reset hold:
  - While asyncReset is 1, Q is held at RESET_VALUE.
  - Clock edges and D changes are ignored.
- Reset release:
  - Deassertion takes effect with no delay.
  - The first rising clk edge with asyncReset = 0 captures D.
  - No additional delay cycles.
- Normal operation:
  - On each rising clk edge with asyncReset = 0, Q <= D.
  - Latency is one edge: a D change is visible on Q after the next rising edge, never before.
- D must satisfy setup/hold around the rising edge. Changes between edges do not affect Q.
- notQ is always exactly ~Q, bitwise, in the same delta cycle. It is never independently registered and never equal to Q.
- Simultaneous events:
  - Reset asserted at the same time as a rising clk edge: reset wins, Q = RESET_VALUE.
  - Reset released at the same time as a rising clk edge: that edge is not guaranteed to capture. Benches must not depend on it.
- Power-up: before the first reset or the first clock edge, Q is unspecified (X in simulation). Benches must not check Q before the first rising edge.
- No other state; no enable in the base configuration.

Optional Feature:
- Macro: DFF_ASYNC_RESET_CLOCK_ENABLE_EN.
- When defined:
  - Adds input port en (1 bit), listed after asyncReset.
  - On a rising clk edge with asyncReset = 0: if en = 1 then Q <= D, else Q holds its value.
  - Reset behaviour is unchanged, and reset overrides en.
- When not defined:
  - No en port.
  - Q <= D on every rising edge with asyncReset = 0, identical to en tied to 1.

Test Plan (clk period 10 ns, first rising edge at 5 ns, WIDTH = 1, RESET_VALUE = 0):
- Capture 0/1: D = 0 from time 0, D = 1 at 30 ns -> Q = 0, notQ = 1 after 5 ns; Q = 1, notQ = 0 after the 35 ns edge, not before.
- Async reset mid-high: with Q = 1, assert asyncReset at 50 ns (between edges) -> Q = 0, notQ = 1 at 50 ns; Q holds 0 through the 55 ns edge even though D = 1.
- Reset release: deassert asyncReset at 60 ns with D = 1 -> Q stays 0 until the 65 ns edge, then Q = 1.
- Toggle tracking: D = 0 at 70 ns, 1 at 80 ns, 0 at 90 ns -> Q = 0 at 75 ns, 1 at 85 ns, 0 at 95 ns; Q holds 0 through 165 ns; notQ = ~Q throughout.
- Reset vs edge: assert asyncReset coincident with a rising edge while D = 1 -> Q = 0.
- Clock-enable build: en = 0 with D toggling for 3 edges -> Q unchanged; en = 1 -> Q follows D on the next edge; asserting asyncReset with en = 0 -> Q = 0 immediately.
